choice_ctrl_sequencer: RTL and testbench

- Shares the combinational choice-control decoder (7-bit command in, 26-bit control word out) among NREQ requesters using round-robin arbitration.
- Latches the granted command and drives it onto the decoder.
- Registers the decoded control word and holds it valid for a programmable dwell time.
- Acknowledges the granted requester at the end of the transaction. Sits between the command sources and the datapath that consumes the control word.

---
 rtl/choice_ctrl_sequencer_if.sv | 12 +
 rtl/choice_ctrl_sequencer.sv | 135 +++++++++++++
 tb/tb_choice_ctrl_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/choice_ctrl_sequencer_if.sv
// rtl/choice_ctrl_sequencer_if.sv - requester bundle between command sources and the sequencer
interface choice_ctrl_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int CMD_W = 7
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*CMD_W-1:0] req_cmd;
  logic [NREQ-1:0]       req_ready;

  modport master (output req_valid, output req_cmd, input req_ready);
  modport slave  (input req_valid, input req_cmd, output req_ready);
endinterface

// File: rtl/choice_ctrl_sequencer.sv
// rtl/choice_ctrl_sequencer.sv - round-robin sharing of the choice-control decoder
module choice_ctrl_sequencer #(
  parameter int NREQ    = 4,
  parameter int CMD_W   = 7,
  parameter int CW_W    = 26,
  parameter int DWELL_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  choice_ctrl_sequencer_if.slave    req_bus,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [CMD_W-1:0]          dec_cmd,
  input  logic [CW_W-1:0]           dec_cw,
  output logic [CW_W-1:0]           cw_out,
  output logic                      cw_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          txn_count
);
  localparam int GID_W = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_HOLD, S_RELEASE} state_e;

  state_e             state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CW_W-1:0]    cw_q, cw_d;
  logic               cw_valid_q, cw_valid_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [NREQ-1:0]    ready_vec;

  logic               arb_found;
  logic [GID_W-1:0]   arb_idx;
  logic [GID_W-1:0]   arb_winner;
  logic [CMD_W-1:0]   arb_cmd;

  // Search starts at rr_ptr and wraps modulo NREQ, so non-power-of-two NREQ never yields an out-of-range index.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_winner = '0;
    arb_cmd    = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = GID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!arb_found && req_bus.req_valid[arb_idx]) begin
        arb_found  = 1'b1;
        arb_winner = arb_idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (arb_winner == GID_W'(i)) begin
        arb_cmd = req_bus.req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
      txn_q      <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    cw_d       = cw_q;
    cw_valid_d = cw_valid_q;
    txn_d      = txn_q;
    ready_vec  = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_winner;
          cmd_d   = arb_cmd;
          cnt_d   = dwell;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cw_d       = dec_cw;
        cw_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        // Valid drops as HOLD ends so the datapath sees exactly dwell+1 valid cycles.
        if (cnt_q == '0) begin
          cw_valid_d = 1'b0;
          state_d    = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: begin
        for (int i = 0; i < NREQ; i++) begin
          ready_vec[i] = (grant_q == GID_W'(i));
        end
        cw_valid_d = 1'b0;
        rr_ptr_d   = (grant_q == GID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        txn_d      = txn_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_bus.req_ready = ready_vec;
  assign dec_cmd           = cmd_q;
  assign cw_out            = cw_q;
  assign cw_valid          = cw_valid_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != S_IDLE);
  assign txn_count         = txn_q;
endmodule

// File: tb/tb_choice_ctrl_sequencer.sv
// tb/tb_choice_ctrl_sequencer.sv - directed self-checking bench for choice_ctrl_sequencer
module tb_choice_ctrl_sequencer;
  localparam int NREQ  = 4;
  localparam int CMD_W = 7;
  localparam int CW_W  = 26;
  localparam int DW_W  = 4;
  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic [DW_W-1:0]   dwell;
  logic [CMD_W-1:0]  dec_cmd;
  logic [CW_W-1:0]   dec_cw;
  logic [CW_W-1:0]   cw_out;
  logic              cw_valid;
  logic [1:0]        grant_id;
  logic              busy;
  logic [CNT_W-1:0]  txn_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_txn = 0;
  bit drop_on_ready = 0;

  choice_ctrl_sequencer_if #(.NREQ(NREQ), .CMD_W(CMD_W)) bus ();

  choice_ctrl_sequencer #(
    .NREQ(NREQ), .CMD_W(CMD_W), .CW_W(CW_W), .DWELL_W(DW_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_bus(bus), .dwell(dwell),
    .dec_cmd(dec_cmd), .dec_cw(dec_cw), .cw_out(cw_out), .cw_valid(cw_valid),
    .grant_id(grant_id), .busy(busy), .txn_count(txn_count)
  );

  assign dec_cw = {{(CW_W-CMD_W){1'b0}}, dec_cmd};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cw_valid", cw_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cw_out", cw_out, 0);
    check("rst_txn", txn_count, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_dec_cmd", dec_cmd, 0);
    rst = 1'b0;
    exp_txn = 0;
  endtask

  // c=1 is the DECODE cycle; HOLD is c=2..dw+2, RELEASE c=dw+3, IDLE c=dw+4.
  task automatic run_txn(input int dw, input int exp_id, input logic [CMD_W-1:0] exp_cmd, input bit perturb);
    int w;
    int vcnt;
    int rdy_c;
    logic [NREQ-1:0] rdy_v;
    w = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end while (!busy && w < 50);
    check("grant_wait", w, 1);
    if (!busy) return;
    check("grant_id", grant_id, exp_id);
    check("dec_cmd", dec_cmd, exp_cmd);
    check("decode_valid_low", cw_valid, 0);
    vcnt  = 0;
    rdy_c = 0;
    rdy_v = '0;
    for (int c = 2; c <= dw + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (perturb && c == 2) begin
        dwell = 4'd1;
        bus.req_cmd[exp_id*CMD_W +: CMD_W] = ~exp_cmd;
      end
      if (cw_valid) vcnt++;
      if (bus.req_ready != '0) begin
        if (rdy_c == 0) begin
          rdy_c = c;
          rdy_v = bus.req_ready;
        end else begin
          rdy_c = 99;
        end
        if (drop_on_ready) bus.req_valid[exp_id] = 1'b0;
      end
    end
    exp_txn++;
    check("valid_cycles", vcnt, dw + 1);
    check("cw_out", cw_out, {{(CW_W-CMD_W){1'b0}}, exp_cmd});
    check("ready_cycle", rdy_c, dw + 3);
    check("ready_onehot", rdy_v, 32'(1) << exp_id);
    check("idle_after", busy, 0);
    check("txn_count", txn_count, exp_txn % (1 << CNT_W));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clk = 1'b0;
    rst = 1'b1;
    dwell = '0;
    bus.req_valid = '0;
    bus.req_cmd = '0;
    do_reset();

    // single request, dwell 2
    dwell = 4'd2;
    bus.req_cmd = {7'h00, 7'h00, 7'h00, 7'h55};
    bus.req_valid = 4'b0001;
    drop_on_ready = 1;
    run_txn(2, 0, 7'h55, 0);

    // round robin from a fresh pointer
    do_reset();
    drop_on_ready = 0;
    dwell = 4'd0;
    bus.req_cmd = {7'h04, 7'h03, 7'h02, 7'h01};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) run_txn(0, k % 4, 7'((k % 4) + 1), 0);

    // rotation skip: grant 1 then only 0 and 3 pending
    bus.req_valid = 4'b0010;
    drop_on_ready = 1;
    run_txn(0, 1, 7'h02, 0);
    bus.req_valid = 4'b1001;
    run_txn(0, 3, 7'h04, 0);
    run_txn(0, 0, 7'h01, 0);

    // dwell boundaries and in-flight changes
    bus.req_cmd = {7'h04, 7'h03, 7'h02, 7'h2A};
    dwell = 4'd15;
    bus.req_valid = 4'b0100;
    run_txn(15, 2, 7'h03, 0);
    dwell = 4'd0;
    bus.req_valid = 4'b0100;
    run_txn(0, 2, 7'h03, 0);
    dwell = 4'd3;
    bus.req_valid = 4'b0001;
    run_txn(3, 0, 7'h2A, 1);

    // reset in the second HOLD cycle
    dwell = 4'd5;
    bus.req_cmd = {7'h44, 7'h33, 7'h22, 7'h11};
    bus.req_valid = 4'b0011;
    w = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end while (!busy && w < 10);
    check("pre_rst_grant", grant_id, 1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_valid", cw_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", cw_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cw_out", cw_out, 0);
    check("mid_rst_txn", txn_count, 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_ready", bus.req_ready, 0);
    end
    rst = 1'b0;
    exp_txn = 0;
    run_txn(5, 0, 7'h11, 0);
    run_txn(5, 1, 7'h22, 0);

    // counter wrap with arbitration continuing from rr_ptr=2
    drop_on_ready = 0;
    dwell = 4'd0;
    bus.req_cmd = {7'h04, 7'h03, 7'h02, 7'h01};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 15; k++) run_txn(0, (2 + k) % 4, 7'(((2 + k) % 4) + 1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
